// File: rtl/axil_fifo_client_pkg.sv
// rtl/axil_fifo_client_pkg.sv - state encoding and AXI response codes for axil_fifo_client
package axil_fifo_client_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    RD_WAIT = 3'd2,
    WR_RESP = 3'd3,
    RD_RESP = 3'd4
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/bsg_dff_reset_en.sv
// rtl/bsg_dff_reset_en.sv - enabled register with synchronous active-high reset to zero
module bsg_dff_reset_en #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_o <= '0;
    end else if (en_i) begin
      data_o <= data_i;
    end
  end

endmodule

// File: rtl/axil_fifo_client.sv
// rtl/axil_fifo_client.sv - AXI-Lite slave bridging single-beat reads/writes onto a valid/ready FIFO request port
// Optional decode-error responses are enabled with AXIL_FIFO_CLIENT_DECERR_EN.
module axil_fifo_client
  import axil_fifo_client_pkg::*;
#(
  parameter int                           axil_data_width_p = 32,
  parameter int                           axil_addr_width_p = 32,
  parameter logic [axil_addr_width_p-1:0] addr_limit_p      = '1
) (
  input  logic                           clk_i,
  input  logic                           reset_i,

  input  logic [axil_addr_width_p-1:0]   s_axil_awaddr_i,
  input  logic [2:0]                     s_axil_awprot_i,
  input  logic                           s_axil_awvalid_i,
  output logic                           s_axil_awready_o,

  input  logic [axil_data_width_p-1:0]   s_axil_wdata_i,
  input  logic [axil_data_width_p/8-1:0] s_axil_wstrb_i,
  input  logic                           s_axil_wvalid_i,
  output logic                           s_axil_wready_o,

  output logic [1:0]                     s_axil_bresp_o,
  output logic                           s_axil_bvalid_o,
  input  logic                           s_axil_bready_i,

  input  logic [axil_addr_width_p-1:0]   s_axil_araddr_i,
  input  logic [2:0]                     s_axil_arprot_i,
  input  logic                           s_axil_arvalid_i,
  output logic                           s_axil_arready_o,

  output logic [axil_data_width_p-1:0]   s_axil_rdata_o,
  output logic [1:0]                     s_axil_rresp_o,
  output logic                           s_axil_rvalid_o,
  input  logic                           s_axil_rready_i,

  output logic [axil_data_width_p-1:0]   data_o,
  output logic [axil_addr_width_p-1:0]   addr_o,
  output logic [axil_data_width_p/8-1:0] wmask_o,
  output logic                           w_o,
  output logic                           v_o,
  input  logic                           ready_and_i,

  input  logic [axil_data_width_p-1:0]   data_i,
  input  logic                           v_i,
  output logic                           ready_and_o
);

  localparam int strb_width_lp = axil_data_width_p / 8;
  localparam int req_width_lp  = axil_addr_width_p + axil_data_width_p + strb_width_lp + 1;

  state_e     state_q;
  logic       prefer_read_q;
  logic [1:0] bresp_q;
  logic [1:0] rresp_q;

  logic wr_elig, rd_elig, in_idle;
  logic take_write, take_read, accept;
  logic decerr;
  logic capture;
  logic unused_inputs;

  logic [req_width_lp-1:0]      req_d, req_q;
  logic [axil_data_width_p-1:0] rdata_d, rdata_q;
  logic                         rdata_en;

  assign wr_elig = s_axil_awvalid_i & s_axil_wvalid_i;
  assign rd_elig = s_axil_arvalid_i;
  // Ready pulses are gated by reset so nothing is accepted while reset is held.
  assign in_idle = (state_q == IDLE) & ~reset_i;

  assign take_write = in_idle & wr_elig & (~rd_elig | ~prefer_read_q);
  assign take_read  = in_idle & rd_elig & ~take_write;
  assign accept     = take_write | take_read;

`ifdef AXIL_FIFO_CLIENT_DECERR_EN
  assign decerr = take_write ? (s_axil_awaddr_i > addr_limit_p)
                             : (s_axil_araddr_i > addr_limit_p);
  assign unused_inputs = ^{s_axil_awprot_i, s_axil_arprot_i};
`else
  assign decerr = 1'b0;
  assign unused_inputs = ^{s_axil_awprot_i, s_axil_arprot_i, addr_limit_p};
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      prefer_read_q <= 1'b0;
      bresp_q       <= RESP_OKAY;
      rresp_q       <= RESP_OKAY;
    end else begin
      case (state_q)
        IDLE: begin
          if (take_write) begin
            prefer_read_q <= 1'b1;
            bresp_q       <= decerr ? RESP_DECERR : RESP_OKAY;
            state_q       <= decerr ? WR_RESP : REQ;
          end else if (take_read) begin
            prefer_read_q <= 1'b0;
            rresp_q       <= decerr ? RESP_DECERR : RESP_OKAY;
            state_q       <= decerr ? RD_RESP : REQ;
          end
        end
        REQ: begin
          if (ready_and_i) begin
            state_q <= w_o ? WR_RESP : RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (v_i) begin
            state_q <= RD_RESP;
          end
        end
        WR_RESP: begin
          if (s_axil_bready_i) begin
            state_q <= IDLE;
          end
        end
        RD_RESP: begin
          if (s_axil_rready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Reads carry zero data and mask so the consumer sees a clean request.
  assign req_d = take_write
               ? {s_axil_awaddr_i, s_axil_wdata_i, s_axil_wstrb_i, 1'b1}
               : {s_axil_araddr_i, {axil_data_width_p{1'b0}}, {strb_width_lp{1'b0}}, 1'b0};

  bsg_dff_reset_en #(
    .width_p(req_width_lp)
  ) req_reg (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en_i   (accept),
    .data_i (req_d),
    .data_o (req_q)
  );

  assign {addr_o, data_o, wmask_o, w_o} = req_q;

  assign capture  = (state_q == RD_WAIT) & v_i;
  assign rdata_en = capture | (take_read & decerr);
  assign rdata_d  = capture ? data_i : '0;

  bsg_dff_reset_en #(
    .width_p(axil_data_width_p)
  ) rdata_reg (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en_i   (rdata_en),
    .data_i (rdata_d),
    .data_o (rdata_q)
  );

  assign s_axil_awready_o = take_write;
  assign s_axil_wready_o  = take_write;
  assign s_axil_arready_o = take_read;

  assign s_axil_bvalid_o  = (state_q == WR_RESP);
  assign s_axil_bresp_o   = bresp_q;
  assign s_axil_rvalid_o  = (state_q == RD_RESP);
  assign s_axil_rresp_o   = rresp_q;
  assign s_axil_rdata_o   = rdata_q;

  assign v_o         = (state_q == REQ);
  assign ready_and_o = (state_q == RD_WAIT);

endmodule

// File: tb/tb_axil_fifo_client.sv
// tb/tb_axil_fifo_client.sv - self-checking bench for axil_fifo_client with a transaction-level model
module tb_axil_fifo_client;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;
`ifdef AXIL_FIFO_CLIENT_DECERR_EN
  localparam logic [AW-1:0] LIMIT = 32'h0000_0FFF;
`else
  localparam logic [AW-1:0] LIMIT = '1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i;
  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          awvalid, awready;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          wvalid, wready;
  logic [1:0]    bresp;
  logic          bvalid, bready;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          arvalid, arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid, rready;
  logic [DW-1:0] data_o;
  logic [AW-1:0] addr_o;
  logic [SW-1:0] wmask_o;
  logic          w_o, v_o, ready_and_i;
  logic [DW-1:0] data_i;
  logic          v_i, ready_and_o;

  int  checks = 0;
  int  errors = 0;
  logic m_prefer_read;
  byte order_q[$];

  axil_fifo_client #(
    .axil_data_width_p(DW),
    .axil_addr_width_p(AW),
    .addr_limit_p     (LIMIT)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .s_axil_awaddr_i (awaddr),
    .s_axil_awprot_i (awprot),
    .s_axil_awvalid_i(awvalid),
    .s_axil_awready_o(awready),
    .s_axil_wdata_i  (wdata),
    .s_axil_wstrb_i  (wstrb),
    .s_axil_wvalid_i (wvalid),
    .s_axil_wready_o (wready),
    .s_axil_bresp_o  (bresp),
    .s_axil_bvalid_o (bvalid),
    .s_axil_bready_i (bready),
    .s_axil_araddr_i (araddr),
    .s_axil_arprot_i (arprot),
    .s_axil_arvalid_i(arvalid),
    .s_axil_arready_o(arready),
    .s_axil_rdata_o  (rdata),
    .s_axil_rresp_o  (rresp),
    .s_axil_rvalid_o (rvalid),
    .s_axil_rready_i (rready),
    .data_o          (data_o),
    .addr_o          (addr_o),
    .wmask_o         (wmask_o),
    .w_o             (w_o),
    .v_o             (v_o),
    .ready_and_i     (ready_and_i),
    .data_i          (data_i),
    .v_i             (v_i),
    .ready_and_o     (ready_and_o)
  );

  task automatic drive_idle();
    awaddr = '0; awprot = 3'd0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0;
    araddr = '0; arprot = 3'd0; arvalid = 1'b0;
    bready = 1'b0; rready = 1'b0; ready_and_i = 1'b0;
    data_i = '0; v_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    drive_idle();
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    #1;
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, v_o, ready_and_o, w_o} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000000",
               {awready, wready, arready, bvalid, rvalid, v_o, ready_and_o, w_o});
    end
    checks++;
    if ({bresp, rresp, rdata, data_o, addr_o, wmask_o} !== '0) begin
      errors++;
      $display("FAIL reset_data got bresp=%h rresp=%h rdata=%h data=%h addr=%h wmask=%h want all 0",
               bresp, rresp, rdata, data_o, addr_o, wmask_o);
    end
    @(negedge clk);
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    #1;
    checks++;
    if ({awready, wready, arready} !== 3'b110) begin
      errors++;
      $display("FAIL reset_rr_write_first got %b want 110", {awready, wready, arready});
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    m_prefer_read = 1'b0;
  endtask

  task automatic test_single_write();
    @(negedge clk);
    awaddr = 32'h40; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; ready_and_i = 1'b1; bready = 1'b1;
    #1;
    checks++;
    if ({awready, wready, arready} !== 3'b110) begin
      errors++;
      $display("FAIL wr_accept got %b want 110", {awready, wready, arready});
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    #1;
    checks++;
    if ({v_o, w_o, addr_o, data_o, wmask_o} !== {1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF}) begin
      errors++;
      $display("FAIL wr_req got v=%b w=%b addr=%h data=%h mask=%h want 1 1 40 deadbeef f",
               v_o, w_o, addr_o, data_o, wmask_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bvalid, bresp, v_o} !== 4'b1000) begin
      errors++;
      $display("FAIL wr_bresp got bvalid=%b bresp=%b v=%b want 1 00 0", bvalid, bresp, v_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bvalid !== 1'b0) begin
      errors++;
      $display("FAIL wr_bdone got bvalid=%b want 0", bvalid);
    end
    m_prefer_read = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    araddr = 32'h40; arvalid = 1'b1; ready_and_i = 1'b1; rready = 1'b1; v_i = 1'b0;
    #1;
    checks++;
    if ({awready, arready} !== 2'b01) begin
      errors++;
      $display("FAIL rd_accept got aw=%b ar=%b want 0 1", awready, arready);
    end
    @(negedge clk);
    arvalid = 1'b0;
    #1;
    checks++;
    if ({v_o, w_o, addr_o, data_o, wmask_o} !== {1'b1, 1'b0, 32'h40, 32'h0, 4'h0}) begin
      errors++;
      $display("FAIL rd_req got v=%b w=%b addr=%h data=%h mask=%h want 1 0 40 0 0",
               v_o, w_o, addr_o, data_o, wmask_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({ready_and_o, rvalid, v_o} !== 3'b100) begin
        errors++;
        $display("FAIL rd_stall got rdy=%b rvalid=%b v=%b want 1 0 0", ready_and_o, rvalid, v_o);
      end
    end
    @(negedge clk);
    v_i = 1'b1; data_i = 32'h1234_5678;
    #1;
    checks++;
    if (ready_and_o !== 1'b1) begin
      errors++;
      $display("FAIL rd_capture got ready_and_o=%b want 1", ready_and_o);
    end
    @(negedge clk);
    v_i = 1'b0; data_i = '0;
    #1;
    checks++;
    if ({rvalid, rresp, rdata, ready_and_o} !== {1'b1, 2'b00, 32'h1234_5678, 1'b0}) begin
      errors++;
      $display("FAIL rd_resp got rvalid=%b rresp=%b rdata=%h rdy=%b want 1 00 12345678 0",
               rvalid, rresp, rdata, ready_and_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_rdone got rvalid=%b want 0", rvalid);
    end
    m_prefer_read = 1'b0;
  endtask

  // pv is the percentage chance each cycle that a master/consumer is willing.
  task automatic run_traffic(input int n_txn, input int pv);
    logic          wp, rp, busy, ex_w, req_done, capt, vi_taken;
    logic          tw, tr;
    logic [AW-1:0] wa, ra, ex_a;
    logic [DW-1:0] wd, ex_d, cap_d;
    logic [SW-1:0] ws, ex_s;
    int            acc, cyc_n;
    wp = 1'b0; rp = 1'b0; busy = 1'b0; ex_w = 1'b0; req_done = 1'b0;
    capt = 1'b0; vi_taken = 1'b0;
    wa = '0; ra = '0; ex_a = '0; wd = '0; ex_d = '0; cap_d = '0; ws = '0; ex_s = '0;
    acc = 0; cyc_n = 0;
    v_i = 1'b0;
    order_q.delete();
    while (acc < n_txn || busy) begin
      @(negedge clk);
      if (vi_taken) begin
        v_i = 1'b0;
        vi_taken = 1'b0;
      end
      if (!wp && (acc + int'(rp)) < n_txn && int'($urandom_range(99)) < pv) begin
        wp = 1'b1; wa = $urandom & 32'h0000_0FFC; wd = $urandom; ws = SW'($urandom);
      end
      if (!rp && (acc + int'(wp)) < n_txn && int'($urandom_range(99)) < pv) begin
        rp = 1'b1; ra = $urandom & 32'h0000_0FFC;
      end
      awaddr = wa; wdata = wd; wstrb = ws; araddr = ra;
      awprot = 3'($urandom); arprot = 3'($urandom);
      awvalid = wp && (pv >= 100 || $urandom_range(3) != 0);
      wvalid  = wp && (pv >= 100 || $urandom_range(3) != 0);
      arvalid = rp && (pv >= 100 || $urandom_range(3) != 0);
      ready_and_i = (pv >= 100) || ($urandom_range(1) == 1);
      bready      = (pv >= 100) || ($urandom_range(1) == 1);
      rready      = (pv >= 100) || ($urandom_range(1) == 1);
      if (!v_i && (pv >= 100 || $urandom_range(2) == 0)) begin
        v_i = 1'b1; data_i = $urandom;
      end
      #1;
      tw = !busy && awvalid && wvalid && (!arvalid || !m_prefer_read);
      tr = !busy && arvalid && !tw;
      checks++;
      if ({awready, wready, arready} !== {tw, tw, tr}) begin
        errors++;
        $display("FAIL trf_ready cyc=%0d got %b want %b", cyc_n, {awready, wready, arready}, {tw, tw, tr});
      end
      checks++;
      if ({v_o, ready_and_o, bvalid, rvalid} !==
          {busy && !req_done, busy && !ex_w && req_done && !capt,
           busy && ex_w && req_done, busy && !ex_w && capt}) begin
        errors++;
        $display("FAIL trf_state cyc=%0d got v/rdy/b/r=%b want %b", cyc_n,
                 {v_o, ready_and_o, bvalid, rvalid},
                 {busy && !req_done, busy && !ex_w && req_done && !capt,
                  busy && ex_w && req_done, busy && !ex_w && capt});
      end
      if (busy && !req_done) begin
        checks++;
        if ({addr_o, data_o, wmask_o, w_o} !== {ex_a, ex_w ? ex_d : '0, ex_w ? ex_s : '0, ex_w}) begin
          errors++;
          $display("FAIL trf_req cyc=%0d got a=%h d=%h m=%h w=%b want a=%h d=%h m=%h w=%b", cyc_n,
                   addr_o, data_o, wmask_o, w_o, ex_a, ex_w ? ex_d : '0, ex_w ? ex_s : '0, ex_w);
        end
      end
      if (busy && ex_w && req_done) begin
        checks++;
        if (bresp !== 2'b00) begin
          errors++;
          $display("FAIL trf_bresp got %b want 00", bresp);
        end
      end
      if (busy && !ex_w && capt) begin
        checks++;
        if ({rresp, rdata} !== {2'b00, cap_d}) begin
          errors++;
          $display("FAIL trf_rdata got rresp=%b rdata=%h want 00 %h", rresp, rdata, cap_d);
        end
      end
      if (busy) begin
        if (!req_done) begin
          if (ready_and_i) req_done = 1'b1;
        end else if (ex_w) begin
          if (bready) busy = 1'b0;
        end else if (!capt) begin
          if (v_i) begin
            capt = 1'b1; cap_d = data_i; vi_taken = 1'b1;
          end
        end else if (rready) begin
          busy = 1'b0;
        end
      end else if (tw || tr) begin
        busy = 1'b1; ex_w = tw; ex_a = tw ? wa : ra; ex_d = wd; ex_s = ws;
        req_done = 1'b0; capt = 1'b0;
        m_prefer_read = tw;
        order_q.push_back(tw ? 8'h57 : 8'h52);
        if (tw) wp = 1'b0; else rp = 1'b0;
        acc++;
      end
      cyc_n++;
      if (cyc_n > 4000) begin
        errors++;
        $display("FAIL trf_timeout accepted=%0d want %0d", acc, n_txn);
        break;
      end
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_simultaneous();
    logic [31:0] ord;
    ord = '0;
    run_traffic(4, 100);
    foreach (order_q[i]) ord = {ord[23:0], order_q[i]};
    checks++;
    if (order_q.size() != 4 || ord !== 32'h5752_5752) begin
      errors++;
      $display("FAIL simul_order got n=%0d order=%h want 4 57525752 (WRWR)", order_q.size(), ord);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d;
    d = $urandom;
    @(negedge clk);
    awaddr = 32'h80; wdata = d; wstrb = 4'h5; awvalid = 1'b1; wvalid = 1'b1;
    ready_and_i = 1'b0; bready = 1'b0;
    #1;
    checks++;
    if ({awready, wready} !== 2'b11) begin
      errors++;
      $display("FAIL bp_wr_accept got %b want 11", {awready, wready});
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; awaddr = '0; wdata = '0; wstrb = '0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if ({v_o, w_o, addr_o, data_o, wmask_o} !== {1'b1, 1'b1, 32'h80, d, 4'h5}) begin
        errors++;
        $display("FAIL bp_req_hold i=%0d got v=%b w=%b a=%h d=%h m=%h want 1 1 80 %h 5",
                 i, v_o, w_o, addr_o, data_o, wmask_o, d);
      end
    end
    @(negedge clk);
    ready_and_i = 1'b1;
    @(negedge clk);
    ready_and_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if ({bvalid, v_o} !== 2'b10) begin
        errors++;
        $display("FAIL bp_b_hold i=%0d got bvalid=%b v=%b want 1 0", i, bvalid, v_o);
      end
    end
    @(negedge clk);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    d = $urandom;
    araddr = 32'h84; arvalid = 1'b1; ready_and_i = 1'b1; rready = 1'b0;
    v_i = 1'b1; data_i = d;
    #1;
    checks++;
    if ({bvalid, arready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_rd_accept got bvalid=%b arready=%b want 0 1", bvalid, arready);
    end
    @(negedge clk);
    arvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    v_i = 1'b0; data_i = '0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if ({rvalid, rdata} !== {1'b1, d}) begin
        errors++;
        $display("FAIL bp_r_hold i=%0d got rvalid=%b rdata=%h want 1 %h", i, rvalid, rdata, d);
      end
    end
    @(negedge clk);
    rready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (rvalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_r_done got rvalid=%b want 0", rvalid);
    end
    drive_idle();
    m_prefer_read = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    d = $urandom;
    @(negedge clk);
    araddr = 32'hC0; arvalid = 1'b1; ready_and_i = 1'b1; rready = 1'b1; v_i = 1'b0;
    @(negedge clk);
    arvalid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (ready_and_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_rdwait got ready_and_o=%b want 1", ready_and_o);
    end
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, v_o, ready_and_o, w_o, bresp, rresp,
         rdata, data_o, addr_o, wmask_o} !== '0) begin
      errors++;
      $display("FAIL rstmid_zero got ctrl=%b addr=%h data=%h rdata=%h want all 0",
               {awready, wready, arready, bvalid, rvalid, v_o, ready_and_o, w_o},
               addr_o, data_o, rdata);
    end
    reset_i = 1'b0;
    @(negedge clk);
    araddr = 32'hC4; arvalid = 1'b1;
    #1;
    checks++;
    if (arready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_accept got arready=%b want 1", arready);
    end
    @(negedge clk);
    arvalid = 1'b0;
    #1;
    checks++;
    if ({v_o, w_o, addr_o} !== {1'b1, 1'b0, 32'hC4}) begin
      errors++;
      $display("FAIL rstmid_req got v=%b w=%b addr=%h want 1 0 c4", v_o, w_o, addr_o);
    end
    @(negedge clk);
    v_i = 1'b1; data_i = d;
    @(negedge clk);
    v_i = 1'b0;
    #1;
    checks++;
    if ({rvalid, rresp, rdata} !== {1'b1, 2'b00, d}) begin
      errors++;
      $display("FAIL rstmid_resp got rvalid=%b rresp=%b rdata=%h want 1 00 %h", rvalid, rresp, rdata, d);
    end
    @(negedge clk);
    drive_idle();
    m_prefer_read = 1'b0;
  endtask

`ifdef AXIL_FIFO_CLIENT_DECERR_EN
  task automatic test_decerr();
    @(negedge clk);
    araddr = 32'h1000; arvalid = 1'b1; ready_and_i = 1'b1; rready = 1'b0;
    #1;
    checks++;
    if (arready !== 1'b1) begin
      errors++;
      $display("FAIL decerr_rd_accept got arready=%b want 1", arready);
    end
    @(negedge clk);
    arvalid = 1'b0;
    #1;
    checks++;
    if ({v_o, rvalid, rresp, rdata} !== {1'b0, 1'b1, 2'b11, 32'h0}) begin
      errors++;
      $display("FAIL decerr_rd got v=%b rvalid=%b rresp=%b rdata=%h want 0 1 11 0", v_o, rvalid, rresp, rdata);
    end
    rready = 1'b1;
    @(negedge clk);
    awaddr = 32'h2000; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    #1;
    checks++;
    if ({v_o, bvalid, bresp} !== 4'b0111) begin
      errors++;
      $display("FAIL decerr_wr got v=%b bvalid=%b bresp=%b want 0 1 11", v_o, bvalid, bresp);
    end
    bready = 1'b1;
    @(negedge clk);
    drive_idle();
    m_prefer_read = 1'b1;
  endtask
`endif

  task automatic test_random();
    run_traffic(60, 50);
  endtask

  initial begin
    m_prefer_read = 1'b0;
    test_reset();
    test_single_write();
    test_single_read();
    test_simultaneous();
    test_backpressure();
    test_reset_mid();
`ifdef AXIL_FIFO_CLIENT_DECERR_EN
    test_decerr();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_fifo_client.md
# axil_fifo_client

AXI4-Lite slave that converts single-beat AXI-Lite reads and writes into the valid/ready FIFO request/response interface used by `bsg_axil_fifo_master`. It sits at the PL end of an AXI-Lite port and lets a FIFO-style consumer (memory model, CSR file, DRAM test harness) be driven over AXI-Lite. One transaction is in flight at a time.

## Interface
- `axil_data_width_p`, 32: AXI-Lite data width (32 or 64).
- `axil_addr_width_p`, 32: AXI-Lite address width.
- `addr_limit_p`, 2**axil_addr_width_p-1: highest legal byte address. Used only with the decode-error feature.
- `clk_i`  in  1  clock; one clock domain.
- `reset_i`  in  1  synchronous, active-high reset.
- `s_axil_aw{addr,prot,valid}_i` / `s_axil_awready_o`: AXI-Lite write-address channel.
- `s_axil_w{data,strb,valid}_i` / `s_axil_wready_o`: write-data channel. `strb` is data_width/8 bits.
- `s_axil_b{resp,valid}_o` / `s_axil_bready_i`: write-response channel.
- `s_axil_ar{addr,prot,valid}_i` / `s_axil_arready_o`: read-address channel.
- `s_axil_r{data,resp,valid}_o` / `s_axil_rready_i`: read-data channel.
- `data_o`  out  data_width  write data. Zero for reads.
- `addr_o`  out  addr_width  request byte address, passed through unmodified.
- `wmask_o`  out  data_width/8  write strobes. Zero for reads.
- `w_o`  out  1  1 = write, 0 = read.
- `v_o`  out  1  request valid.
- `ready_and_i`  in  1  consumer accepts the request.
- `data_i`  in  data_width  read data returned by the consumer.
- `v_i`  in  1  read data valid.
- `ready_and_o`  out  1  this block accepts read data.

## Operation
- State machine states: IDLE, REQ, RD_WAIT, WR_RESP, RD_RESP.
- IDLE:
  - A write is eligible when `awvalid & wvalid` are both high.
  - A read is eligible when `arvalid` is high.
  - When only one kind is eligible, it is taken.
  - When both are eligible, round-robin applies: the kind not served last is taken. After reset, the write wins first.
  - Accepting a write pulses `awready` and `wready` together for one cycle. Accepting a read pulses `arready` for one cycle.
  - The address, data and strobes are registered, and the state moves to REQ.
- REQ:
  - `v_o` is high and the request fields are stable.
  - On `v_o & ready_and_i`: a write goes to WR_RESP, a read goes to RD_WAIT.
- RD_WAIT:
  - `ready_and_o` is high.
  - On `v_i`, `data_i` is captured and the state moves to RD_RESP.
- WR_RESP: `bvalid` is high with `bresp` = OKAY. On `bready`, return to IDLE.
- RD_RESP: `rvalid` is high with the captured data and `rresp` = OKAY. On `rready`, return to IDLE.
- Writes are acknowledged once the consumer accepts the request. The consumer never returns data for a write.
- `v_i` outside RD_WAIT is not consumed, because `ready_and_o` is low. The consumer holds it.
- `prot` inputs are ignored.

## Timing
- Reset values:
  - All `*ready_o`, `bvalid`, `rvalid`, `v_o` and `ready_and_o` are 0.
  - `bresp`, `rresp`, `rdata`, `data_o`, `addr_o`, `wmask_o` and `w_o` are 0.
  - The state is IDLE and the round-robin pointer selects write.
- Write latency with a consumer that is always ready: handshake at cycle 0, `v_o` at cycle 1, `bvalid` at cycle 2.
- Read latency with `v_i` tied high: AR handshake at cycle 0, `v_o` at cycle 1, capture at cycle 2, `rvalid` at cycle 3.
- All outputs are registered or decoded directly from state. There is no combinational path from any input to any output, except the ready pulses in IDLE, which depend on the `*valid_i` inputs.
- A write with AW valid but W not valid (or the reverse) is not accepted. The channel waits, with `awready` and `wready` low, until both are valid.
- Reset asserted in any state returns the block to IDLE. Any pending request is dropped and no B/R response is issued for it.
- Back-to-back transactions: the next accept can occur in the cycle after the B or R handshake.

## Configuration
- Macro: `AXIL_FIFO_CLIENT_DECERR_EN`.
- Defined:
  - A transaction whose address exceeds `addr_limit_p` skips REQ and RD_WAIT. It goes directly to WR_RESP or RD_RESP with resp = DECERR (2'b11) and `rdata` = 0.
  - `v_o` is never raised for such a transaction.
- Undefined:
  - No address check is performed.
  - Every response is OKAY.
  - `addr_limit_p` is unused.

## Structure
- `axil_fifo_client_pkg` holds:
  - the state enum;
  - the AXI resp constants (OKAY=2'b00, DECERR=2'b11).
- Single module. Round-robin selection is one flop inline.
- Registers use library `bsg_dff_reset_en`. No sub-module beyond library flops.

## Test plan
- **Single write.** AW addr 0x40, W data 0xDEADBEEF, strb 0xF; consumer ready.
  - Cycle 1: `v_o=1`, `w_o=1`, `addr_o=0x40`, `data_o=0xDEADBEEF`.
  - Cycle 2: `bvalid` with OKAY.
- **Single read.** AR 0x40; consumer returns 0x12345678 after a 3-cycle stall.
  - `rvalid` is asserted the cycle after capture, with `rdata=0x12345678`, `rresp` OKAY.
- **Simultaneous read and write** for 4 transactions, all valid every cycle.
  - Service order is W, R, W, R.
  - Each response arrives only after the previous B/R handshake.
- **Backpressure.**
  - Hold `ready_and_i=0` for 10 cycles: `v_o` and request fields stay stable.
  - Hold `rready=0`: `rvalid` and `rdata` stay stable.
  - Hold `bready=0`: `bvalid` stays high.
- **Reset mid-operation.** Assert `reset_i` in RD_WAIT.
  - Next cycle: all outputs are 0.
  - A following read completes normally.
- **Decode error** (with `AXIL_FIFO_CLIENT_DECERR_EN`, `addr_limit_p`=0xFFF). AR 0x1000.
  - `rresp=2'b11`, `rdata=0`, and `v_o` never asserts.
